// File: rtl/shiftout_chain_pkg.sv
// Shared types and helpers for the shiftout_chain serialiser.
package shiftout_chain_pkg;

    // Engine states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOW,
        ST_HIGH,
        ST_SETUP,
        ST_LATCH
    } state_t;

    // Half period of SHIFT_CLOCK in system clocks. It never drops below one cycle.
    function automatic int calc_half(input int clk_freq, input int frequency);
        int h;
        h = clk_freq / (2 * frequency);
        return (h < 1) ? 1 : h;
    endfunction

endpackage

// File: rtl/shiftout_chain_if.sv
// Frame handshake between the display logic (master) and the serialiser (slave).
interface shiftout_chain_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/shiftout_chain_clkdiv.sv
// Half-period tick generator. The tick fires on the last cycle of each half period.
// Holding clear keeps the count at zero, so every timed state starts a full half period.
module shiftout_chain_clkdiv #(
    parameter int HALF = 1
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(HALF + 1);
    localparam logic [CW-1:0] TERM = CW'(HALF - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = !clear && (cnt_reg == TERM);

    // Count up to the terminal value, then reload to zero on the same cycle.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            cnt_reg <= '0;
        end else if (cnt_reg == TERM) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end
endmodule

// File: rtl/shiftout_chain.sv
// Serialises frames into CHANNELS parallel 74HC595-style chains. The chains share one
// shift clock and one latch. A one-word pending buffer lets the next frame queue up
// while the current one is being shifted out.
module shiftout_chain
    import shiftout_chain_pkg::*;
#(
    parameter int CLK_FREQ     = 12_000_000,
    parameter int FREQUENCY    = 1_000_000,
    parameter int DATA_WIDTH   = 32,        // must be >= 2
    parameter int CHANNELS     = 1,
    parameter int MSB_FIRST    = 1,
    parameter int LATCH_CYCLES = 2          // must be >= 1
) (
    input  logic                ICE_CLK,
    input  logic                RESET,
    shiftout_chain_if.slave     host,
    output logic                SHIFT_CLOCK,
    output logic                SHIFT_LATCH,
    output logic [CHANNELS-1:0] SHIFT_DATA,
    output logic                busy,
    output logic                done
);
    localparam int HALF = calc_half(CLK_FREQ, FREQUENCY);
    localparam int FW   = CHANNELS * DATA_WIDTH;
    localparam int BW   = $clog2(DATA_WIDTH + 1);
    localparam int LW   = $clog2(LATCH_CYCLES + 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_WIDTH - 1);
    localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);

    state_t                state_reg, state_next;
    logic [FW-1:0]         pending_reg, pending_next;
    logic                  full_reg, full_next;
    logic [FW-1:0]         shift_reg, shift_next;
    logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
    logic [LW-1:0]         latch_cnt_reg, latch_cnt_next;
    logic                  shift_clock_reg, shift_clock_next;
    logic                  shift_latch_reg, shift_latch_next;
    logic [CHANNELS-1:0]   shift_data_reg, shift_data_next;
    logic                  done_reg, done_next;

    logic                  tick;
    logic                  div_clear;
    logic [CHANNELS-1:0]   first_bits;
    logic [CHANNELS-1:0]   next_bits;
    logic [FW-1:0]         shifted_word;

    // The divider runs only while the shift clock is being timed.
    assign div_clear = !((state_reg == ST_LOW) || (state_reg == ST_HIGH) || (state_reg == ST_SETUP));

    shiftout_chain_clkdiv #(.HALF(HALF)) u_clkdiv (
        .clk   (ICE_CLK),
        .srst  (RESET),
        .clear (div_clear),
        .tick  (tick)
    );

    // Per-channel bit selection and shift direction.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [DATA_WIDTH-1:0] word;
            assign word = shift_reg[gi*DATA_WIDTH +: DATA_WIDTH];
            if (MSB_FIRST != 0) begin : g_msb
                assign first_bits[gi] = word[DATA_WIDTH-1];
                assign next_bits[gi]  = word[DATA_WIDTH-2];
                assign shifted_word[gi*DATA_WIDTH +: DATA_WIDTH] = {word[DATA_WIDTH-2:0], 1'b0};
            end else begin : g_lsb
                assign first_bits[gi] = word[0];
                assign next_bits[gi]  = word[1];
                assign shifted_word[gi*DATA_WIDTH +: DATA_WIDTH] = {1'b0, word[DATA_WIDTH-1:1]};
            end
        end
    endgenerate

    // State and output registers. RESET aborts a frame with no latch pulse.
    always_ff @(posedge ICE_CLK) begin
        if (RESET) begin
            state_reg       <= ST_IDLE;
            pending_reg     <= '0;
            full_reg        <= 1'b0;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            latch_cnt_reg   <= '0;
            shift_clock_reg <= 1'b0;
            shift_latch_reg <= 1'b0;
            shift_data_reg  <= '0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pending_reg     <= pending_next;
            full_reg        <= full_next;
            shift_reg       <= shift_next;
            bit_cnt_reg     <= bit_cnt_next;
            latch_cnt_reg   <= latch_cnt_next;
            shift_clock_reg <= shift_clock_next;
            shift_latch_reg <= shift_latch_next;
            shift_data_reg  <= shift_data_next;
            done_reg        <= done_next;
        end
    end

    // Buffer accept/pop and the frame sequencer.
    always_comb begin
        state_next       = state_reg;
        pending_next     = pending_reg;
        full_next        = full_reg;
        shift_next       = shift_reg;
        bit_cnt_next     = bit_cnt_reg;
        latch_cnt_next   = latch_cnt_reg;
        shift_clock_next = shift_clock_reg;
        shift_latch_next = shift_latch_reg;
        shift_data_next  = shift_data_reg;
        done_next        = 1'b0;

        // Accept and pop never coincide: accept needs the buffer empty and pop needs it full.
        if (host.in_valid && !full_reg) begin
            pending_next = host.in_data;
            full_next    = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (full_reg) begin
                    shift_next = pending_reg;
                    full_next  = 1'b0;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_data_next = first_bits;
                bit_cnt_next    = LAST_BIT;
                state_next      = ST_LOW;
            end
            ST_LOW: begin
                if (tick) begin
                    shift_clock_next = 1'b1;
                    state_next       = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    // Clock falls and the next bit appears on the same edge.
                    shift_clock_next = 1'b0;
                    if (bit_cnt_reg == '0) begin
                        state_next = ST_SETUP;
                    end else begin
                        bit_cnt_next    = bit_cnt_reg - BW'(1);
                        shift_next      = shifted_word;
                        shift_data_next = next_bits;
                        state_next      = ST_LOW;
                    end
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    shift_latch_next = 1'b1;
                    latch_cnt_next   = '0;
                    state_next       = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (latch_cnt_reg == LATCH_LAST) begin
                    shift_latch_next = 1'b0;
                    done_next        = 1'b1;
                    // A queued frame goes straight to LOAD so no idle cycle is inserted.
                    if (full_reg) begin
                        shift_next = pending_reg;
                        full_next  = 1'b0;
                        state_next = ST_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    latch_cnt_next = latch_cnt_reg + LW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign host.in_ready = !full_reg;
    assign SHIFT_CLOCK   = shift_clock_reg;
    assign SHIFT_LATCH   = shift_latch_reg;
    assign SHIFT_DATA    = shift_data_reg;
    assign busy          = (state_reg != ST_IDLE) || full_reg;
    assign done          = done_reg;
endmodule
